lap_stopwatch: RTL and testbench

//  Parametrised stopwatch with integrated rising-edge detection, BCD time base, lap memory
//  and multiplexed-free parallel 7-segment outputs. Counts in ms, shows a selectable
//  NUM_DISP-digit window with 0..3 decimal places. Captures up to LAP_DEPTH lap times
//  for later review. Sits directly behind board-level synchronisers; drives displays.

---
 rtl/lap_stopwatch.sv | 158 +++++++++++++++
 tb/tb_lap_stopwatch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stopwatch.sv
// Stopwatch with edge-detected commands, BCD millisecond counter, lap memory
// and a parallel 7-segment window of NUM_DISP digits.
module lap_stopwatch #(
  parameter int TICK_DIV   = 50000,
  parameter int NUM_DIGITS = 7,
  parameter int NUM_DISP   = 4,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             pause,
  input  logic                             stop,
  input  logic                             lap,
  input  logic                             lap_next,
  input  logic                             lap_view,
  input  logic [1:0]                       decimal_places,
  output logic [8*NUM_DISP-1:0]            display,
  output logic                             running,
  output logic                             pause_indicator,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             lap_full,
  output logic                             wrapped
);

  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DIG_W = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

  state_t           state_q, state_d;
  logic [4:0]       in_q;
  logic [4:0]       in_now;
  logic [4:0]       pulse;
  logic             cmd_stop, cmd_start, cmd_pause, cmd_lap, cmd_next;
  logic [PRE_W-1:0] pre_q;
  bcd_t             cnt_q, cnt_inc, src;
  bcd_t             mem_q [LAP_DEPTH];
  logic [CNT_W-1:0] lap_count_q, lap_idx_q;
  logic             wrapped_q;
  logic             tick, carry;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign in_now = {start, pause, stop, lap, lap_next};
  assign pulse  = in_now & ~in_q;

  // Only the highest-priority pulse of a cycle is acted on; the rest are dropped.
  assign cmd_stop  = pulse[2];
  assign cmd_start = !pulse[2] && pulse[4];
  assign cmd_pause = !pulse[2] && !pulse[4] && pulse[3];
  assign cmd_lap   = !pulse[2] && !pulse[4] && !pulse[3] && pulse[1];
  assign cmd_next  = !pulse[2] && !pulse[4] && !pulse[3] && !pulse[1] && pulse[0];

  // NOTE: every signal driven from always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (cmd_stop)                            state_d = IDLE;
    else if (cmd_start && state_q != RUN)    state_d = RUN;
    else if (cmd_pause && state_q == RUN)    state_d = PAUSED;
  end

  assign tick = (state_q == RUN) && (pre_q == PRE_W'(TICK_DIV - 1));

  // NOTE: blocking assignments here are deliberate; carry must ripple through the loop within one evaluation.
  always_comb begin
    carry   = 1'b1;
    cnt_inc = cnt_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (cnt_q[d] == 4'd9) begin
          cnt_inc[d] = 4'd0;
        end else begin
          cnt_inc[d] = cnt_q[d] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_q        <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      lap_count_q <= '0;
      lap_idx_q   <= '0;
      wrapped_q   <= 1'b0;
      // NOTE: the lap memory is reset too, so a fresh session never exposes stale laps.
      for (int j = 0; j < LAP_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      in_q    <= in_now;
      state_q <= state_d;
      if (cmd_stop) begin
        pre_q       <= '0;
        cnt_q       <= '0;
        lap_count_q <= '0;
        lap_idx_q   <= '0;
        wrapped_q   <= 1'b0;
        for (int j = 0; j < LAP_DEPTH; j++) mem_q[j] <= '0;
      end else begin
        if (state_q == RUN) begin
          if (tick) begin
            pre_q <= '0;
            cnt_q <= cnt_inc;
            if (carry) wrapped_q <= 1'b1;
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        // Lap stores the value shown before this edge's increment.
        if (cmd_lap && state_q != IDLE && !lap_full) begin
          mem_q[IDX_W'(lap_count_q)] <= cnt_q;
          lap_count_q                <= lap_count_q + 1'b1;
        end
        if (cmd_next && lap_count_q != '0) begin
          lap_idx_q <= (lap_idx_q + 1'b1 == lap_count_q) ? '0 : lap_idx_q + 1'b1;
        end
      end
    end
  end

  // Display i shows source digit (3 - decimal_places + i); dp marks the units-of-seconds digit.
  always_comb begin
    src     = (lap_view && lap_count_q != '0) ? mem_q[IDX_W'(lap_idx_q)] : cnt_q;
    display = '0;
    for (int i = 0; i < NUM_DISP; i++) begin
      display[8*i +: 7] = seg7(src[DIG_W'(3 + i) - DIG_W'(decimal_places)]);
      display[8*i + 7]  = (decimal_places != 2'd0) && (int'(decimal_places) == i);
    end
  end

  assign running         = (state_q == RUN);
  assign pause_indicator = (state_q == PAUSED);
  assign lap_count       = lap_count_q;
  assign lap_full        = (lap_count_q == CNT_W'(LAP_DEPTH));
  assign wrapped         = wrapped_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: a millisecond-integer reference model predicts
// every cycle's outputs; a small second instance covers counter wrap-around.
module tb_lap_stopwatch;

  localparam int TICK_DIV   = 2;
  localparam int NUM_DIGITS = 7;
  localparam int NUM_DISP   = 4;
  localparam int LAP_DEPTH  = 4;
  localparam int MOD        = 10 ** NUM_DIGITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, pause, stop, lap, lap_next, lap_view;
  logic [1:0]           decimal_places;
  logic [8*NUM_DISP-1:0] display;
  logic                 running, pause_indicator, lap_full, wrapped;
  logic [2:0]           lap_count;

  lap_stopwatch #(
    .TICK_DIV(TICK_DIV), .NUM_DIGITS(NUM_DIGITS), .NUM_DISP(NUM_DISP), .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .lap(lap),
    .lap_next(lap_next), .lap_view(lap_view), .decimal_places(decimal_places),
    .display(display), .running(running), .pause_indicator(pause_indicator),
    .lap_count(lap_count), .lap_full(lap_full), .wrapped(wrapped)
  );

  // Small instance: 4 digits, 1 ms per clk, so all-9s is reachable quickly.
  logic       rst2, start2, pause2, stop2, lap2, lap_next2, lap_view2;
  logic [1:0] dp2;
  logic [7:0] display2;
  logic       running2, paused2, lap_full2, wrapped2;
  logic [0:0] lap_count2;
  bit         done2 = 1'b0;

  lap_stopwatch #(
    .TICK_DIV(1), .NUM_DIGITS(4), .NUM_DISP(1), .LAP_DEPTH(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .pause(pause2), .stop(stop2), .lap(lap2),
    .lap_next(lap_next2), .lap_view(lap_view2), .decimal_places(dp2),
    .display(display2), .running(running2), .pause_indicator(paused2),
    .lap_count(lap_count2), .lap_full(lap_full2), .wrapped(wrapped2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_PAUSED} mode_t;
  typedef struct {
    logic [31:0] display;
    logic        running;
    logic        paused;
    int          lap_count;
    logic        lap_full;
    logic        wrapped;
  } exp_t;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  mode_t    m_mode;
  int       m_ms, m_phase, m_idx;
  bit       m_wrapped;
  int       m_laps[$];
  bit [4:0] m_prev;
  exp_t     exp_q[$];

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_ms      = 0;
    m_phase   = 0;
    m_idx     = 0;
    m_wrapped = 1'b0;
    m_prev    = '0;
    m_laps.delete();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   src;
    int   p;
    src = (lap_view && m_laps.size() > 0) ? m_laps[m_idx] : m_ms;
    p   = int'(decimal_places);
    e.display = '0;
    for (int i = 0; i < NUM_DISP; i++) begin
      int k;
      k = 3 - p + i;
      e.display[8*i +: 7] = seg_tab[(src / (10 ** k)) % 10];
      e.display[8*i + 7]  = (p > 0 && i == p);
    end
    e.running   = (m_mode == M_RUN);
    e.paused    = (m_mode == M_PAUSED);
    e.lap_count = m_laps.size();
    e.lap_full  = (m_laps.size() == LAP_DEPTH);
    e.wrapped   = m_wrapped;
    return e;
  endfunction

  // Advances the model across one rising clock edge using the inputs currently applied.
  task automatic model_step();
    bit [4:0] now, p;
    int       old_ms;
    if (rst) begin
      model_reset();
      return;
    end
    now    = {start, pause, stop, lap, lap_next};
    p      = now & ~m_prev;
    m_prev = now;
    if (p[2]) begin
      m_mode    = M_IDLE;
      m_ms      = 0;
      m_phase   = 0;
      m_idx     = 0;
      m_wrapped = 1'b0;
      m_laps.delete();
      return;
    end
    old_ms = m_ms;
    if (m_mode == M_RUN) begin
      if (m_phase == TICK_DIV - 1) begin
        m_phase = 0;
        m_ms    = m_ms + 1;
        if (m_ms == MOD) begin
          m_ms      = 0;
          m_wrapped = 1'b1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
    if (p[4]) begin
      if (m_mode != M_RUN) m_mode = M_RUN;
    end else if (p[3]) begin
      if (m_mode == M_RUN) m_mode = M_PAUSED;
    end else if (p[1]) begin
      if (m_mode != M_IDLE && m_laps.size() < LAP_DEPTH) m_laps.push_back(old_ms);
    end else if (p[0]) begin
      if (m_laps.size() > 0) m_idx = (m_idx + 1 == m_laps.size()) ? 0 : m_idx + 1;
    end
  endtask

  // Called just after a rising edge: record this cycle's expected outputs, then cross the next edge.
  task automatic step();
    exp_q.push_back(model_out());
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("display",         display,         e.display);
        check("running",         running,         e.running);
        check("pause_indicator", pause_indicator, e.paused);
        check("lap_count",       lap_count,       e.lap_count);
        check("lap_full",        lap_full,        e.lap_full);
        check("wrapped",         wrapped,         e.wrapped);
      end
    end
  end

  // ---------------- wrap-around instance ----------------
  initial begin
    rst2 = 1'b1; start2 = 1'b0; pause2 = 1'b0; stop2 = 1'b0;
    lap2 = 1'b0; lap_next2 = 1'b0; lap_view2 = 1'b0; dp2 = 2'd0;
    @(posedge clk); #1;
    check("w_reset_display", display2, 8'h3F);
    check("w_reset_running", running2, 1'b0);
    rst2 = 1'b0;
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    lap2 = 1'b1; @(posedge clk); #1; lap2 = 1'b0;
    check("w_lap_count", lap_count2, 1'b1);
    check("w_lap_full",  lap_full2,  1'b1);
    repeat (9994) @(posedge clk);
    #1;
    check("w_9999_display", display2, 8'h6F);
    check("w_9999_wrapped", wrapped2, 1'b0);
    dp2 = 2'd3; lap_view2 = 1'b1; #1;
    check("w_lap_view_display", display2, 8'h66);
    dp2 = 2'd0; lap_view2 = 1'b0;
    @(posedge clk); #1;
    check("w_wrap_display", display2, 8'h3F);
    check("w_wrap_flag",    wrapped2, 1'b1);
    check("w_wrap_running", running2, 1'b1);
    stop2 = 1'b1; @(posedge clk); #1; stop2 = 1'b0;
    check("w_stop_wrapped",   wrapped2,   1'b0);
    check("w_stop_lap_count", lap_count2, 1'b0);
    check("w_stop_running",   running2,   1'b0);
    done2 = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    lap = 1'b0; lap_next = 1'b0; lap_view = 1'b0; decimal_places = 2'd3;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;

    // 1 s of running shows "1.000"
    pulse_start();
    repeat (2000) step();
    check("t1_display", display, 32'h863F3F3F);
    check("t1_running", running, 1'b1);

    // pause / resume with held prescaler phase
    do_reset();
    pulse_start();
    repeat (21) step();
    pause = 1'b1; step(); pause = 1'b0;
    repeat (50) step();
    check("t2_paused",  pause_indicator, 1'b1);
    check("t2_running", running, 1'b0);
    pulse_start();
    repeat (5) step();

    // laps at 5,10,15,20 ms, fifth ignored, then review with wrap of lap_next
    do_reset();
    pulse_start();
    repeat (10) step();
    repeat (5) begin
      lap = 1'b1; step(); lap = 1'b0;
      repeat (9) step();
    end
    check("t3_lap_count", lap_count, 3'd4);
    check("t3_lap_full",  lap_full,  1'b1);
    lap_view = 1'b1; #1;
    check("t3_first_lap", display, 32'hBF3F3F6D);
    repeat (4) begin
      lap_next = 1'b1; step(); lap_next = 1'b0;
      repeat (3) step();
    end
    check("t3_lap_wrap", display, 32'hBF3F3F6D);
    lap_view = 1'b0;

    // start+stop+pause together: stop wins
    start = 1'b1; stop = 1'b1; pause = 1'b1; step();
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    check("t4_lap_count", lap_count, 3'd0);
    check("t4_running",   running,   1'b0);
    repeat (4) step();

    // reset mid-run with lap held high
    pulse_start();
    repeat (20) step();
    lap = 1'b1; step();
    do_reset();
    repeat (3) step();
    pulse_start();
    lap = 1'b0; step();
    lap = 1'b1; step();
    lap = 1'b0; step();
    check("t6_lap_count", lap_count, 3'd1);

    // randomized levels
    repeat (6000) begin
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 19)  == 0) start    = ~start;
      if ($urandom_range(0, 24)  == 0) pause    = ~pause;
      if ($urandom_range(0, 299) == 0) stop     = ~stop;
      if ($urandom_range(0, 7)   == 0) lap      = ~lap;
      if ($urandom_range(0, 5)   == 0) lap_next = ~lap_next;
      if ($urandom_range(0, 39)  == 0) lap_view = ~lap_view;
      if ($urandom_range(0, 59)  == 0) decimal_places = 2'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0;

    for (int i = 0; i < 20000 && !done2; i++) @(posedge clk);
    check("wrap_instance_done", done2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
